mem_access_unit: RTL

Memory-access stage of the five-stage RV64 core, the consumer of the EX/MEM pipeline register. It takes the registered destination, write-enable, ALU result and memory-op fields and performs the load or store on the data-memory bus. It aligns and extends load data, and produces the writeback-stage inputs. Non-memory ops pass straight through. Memory ops run a small request/response FSM and back-pressure the pipeline until they complete.

---
 rtl/mem_access_unit_pkg.sv | 78 +++++++
 rtl/mem_lane_align.sv | 62 ++++++
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-access stage: op codes, FSM encoding,
// bus payload layout and small op-decoding helpers.
package mem_access_unit_pkg;

    localparam int unsigned RegBus     = 64;
    localparam int unsigned RegAddrBus = 5;
    localparam int unsigned MemOpW     = 4;
    localparam int unsigned LaneCnt    = 8;

    localparam logic [RegBus-1:0]     ZeroWord     = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
    localparam logic                  WriteDisable = 1'b0;

    localparam logic [MemOpW-1:0] MEM_OP_NONE = 4'd0;
    localparam logic [MemOpW-1:0] MEM_OP_LB   = 4'd1;
    localparam logic [MemOpW-1:0] MEM_OP_LH   = 4'd2;
    localparam logic [MemOpW-1:0] MEM_OP_LW   = 4'd3;
    localparam logic [MemOpW-1:0] MEM_OP_LD   = 4'd4;
    localparam logic [MemOpW-1:0] MEM_OP_LBU  = 4'd5;
    localparam logic [MemOpW-1:0] MEM_OP_LHU  = 4'd6;
    localparam logic [MemOpW-1:0] MEM_OP_LWU  = 4'd7;
    localparam logic [MemOpW-1:0] MEM_OP_SB   = 4'd8;
    localparam logic [MemOpW-1:0] MEM_OP_SH   = 4'd9;
    localparam logic [MemOpW-1:0] MEM_OP_SW   = 4'd10;
    localparam logic [MemOpW-1:0] MEM_OP_SD   = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mau_state_e;

    // Registered data-memory request payload.
    typedef struct packed {
        logic                 we;
        logic [RegBus-1:0]    addr;
        logic [LaneCnt-1:0]   wmask;
        logic [RegBus-1:0]    wdata;
    } dmem_bus_t;

    function automatic logic op_is_load(input logic [MemOpW-1:0] op);
        return (op >= MEM_OP_LB) && (op <= MEM_OP_LWU);
    endfunction

    function automatic logic op_is_store(input logic [MemOpW-1:0] op);
        return (op >= MEM_OP_SB) && (op <= MEM_OP_SD);
    endfunction

    function automatic logic op_is_mem(input logic [MemOpW-1:0] op);
        return op_is_load(op) || op_is_store(op);
    endfunction

    // log2 of the access size in bytes.
    function automatic logic [1:0] op_size_log2(input logic [MemOpW-1:0] op);
        logic [1:0] sz;
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: sz = 2'd0;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: sz = 2'd1;
            MEM_OP_LW, MEM_OP_LWU, MEM_OP_SW: sz = 2'd2;
            default:                          sz = 2'd3;
        endcase
        return sz;
    endfunction

    // An access is misaligned when its lane offset is not a multiple of its size.
    function automatic logic op_misaligned(input logic [MemOpW-1:0] op,
                                           input logic [2:0]        lane);
        logic mis;
        case (op_size_log2(op))
            2'd0:    mis = 1'b0;
            2'd1:    mis = lane[0];
            2'd2:    mis = |lane[1:0];
            default: mis = |lane;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment for an 8-byte data bus.
// Ports:
//   op_i     memory-op code
//   lane_i   byte offset within the 8-byte word (addr[2:0])
//   sdata_i  store source data, lane 0 based
//   rdata_i  raw bus read data
//   wmask_c  byte write mask for stores (0 for other ops)
//   wdata_c  store data shifted to its lane
//   ldata_c  load data extracted from its lane and sign/zero extended
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN = RegBus
)
(
    input  logic [MemOpW-1:0]  op_i,
    input  logic [2:0]         lane_i,
    input  logic [XLEN-1:0]    sdata_i,
    input  logic [XLEN-1:0]    rdata_i,
    output logic [LaneCnt-1:0] wmask_c,
    output logic [XLEN-1:0]    wdata_c,
    output logic [XLEN-1:0]    ldata_c
);

    localparam int unsigned ShW = $clog2(XLEN);

    logic [ShW-1:0]     bit_sh;
    logic [XLEN-1:0]    rshift;
    logic [LaneCnt-1:0] base_mask;

    assign bit_sh  = ShW'({lane_i, 3'b000});
    assign rshift  = rdata_i >> bit_sh;
    assign wdata_c = sdata_i << bit_sh;

    // Load extract: the addressed lane is brought down to bit 0 first.
    always_comb begin
        ldata_c = '0;
        case (op_i)
            MEM_OP_LB:  ldata_c = {{(XLEN-8){rshift[7]}},   rshift[7:0]};
            MEM_OP_LH:  ldata_c = {{(XLEN-16){rshift[15]}}, rshift[15:0]};
            MEM_OP_LW:  ldata_c = {{(XLEN-32){rshift[31]}}, rshift[31:0]};
            MEM_OP_LD:  ldata_c = rshift;
            MEM_OP_LBU: ldata_c = {{(XLEN-8){1'b0}},  rshift[7:0]};
            MEM_OP_LHU: ldata_c = {{(XLEN-16){1'b0}}, rshift[15:0]};
            MEM_OP_LWU: ldata_c = {{(XLEN-32){1'b0}}, rshift[31:0]};
            default:    ldata_c = '0;
        endcase
    end

    // Store mask: size-based lane mask moved up to the addressed lane.
    always_comb begin
        base_mask = '0;
        case (op_size_log2(op_i))
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        wmask_c = op_is_store(op_i) ? (base_mask << lane_i) : '0;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: passes non-memory ops to writeback, runs
// loads/stores over a request/response data-memory bus with back-pressure.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid / in_ready            EX/MEM handshake (ready only in IDLE)
//   mem_wd/mem_wreg/mem_wdata      destination, write enable, ALU result/address
//   mem_op, mem_sdata              memory-op code, store source data
//   dmem_req/ready/we/addr/wmask/wdata   data-memory request channel
//   dmem_rvalid/rdata              data-memory response channel
//   wb_valid/wb_wd/wb_wreg/wb_wdata      writeback outputs (one-cycle pulse)
//   mem_misalign                   one-cycle pulse on a misaligned access
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN   = RegBus,
    parameter int unsigned REG_AW = RegAddrBus
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_AW-1:0]   mem_wd,
    input  logic                mem_wreg,
    input  logic [XLEN-1:0]     mem_wdata,
    input  logic [3:0]          mem_op,
    input  logic [XLEN-1:0]     mem_sdata,
    output logic                dmem_req,
    input  logic                dmem_ready,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [7:0]          dmem_wmask,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_rvalid,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                wb_valid,
    output logic [REG_AW-1:0]   wb_wd,
    output logic                wb_wreg,
    output logic [XLEN-1:0]     wb_wdata,
    output logic                mem_misalign
);

    mau_state_e          state_q, state_d;
    logic [MemOpW-1:0]   op_q, op_d;
    logic [2:0]          lane_q, lane_d;
    logic [REG_AW-1:0]   wd_q, wd_d;
    logic                wreg_q, wreg_d;

    logic                in_ready_q, in_ready_d;
    logic                dmem_req_q, dmem_req_d;
    dmem_bus_t           bus_q, bus_d;
    logic                wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0]   wb_wd_q, wb_wd_d;
    logic                wb_wreg_q, wb_wreg_d;
    logic [XLEN-1:0]     wb_wdata_q, wb_wdata_d;
    logic                misalign_q, misalign_d;

    logic [MemOpW-1:0]   align_op;
    logic [2:0]          align_lane;
    logic [LaneCnt-1:0]  al_wmask_c;
    logic [XLEN-1:0]     al_wdata_c;
    logic [XLEN-1:0]     al_ldata_c;

    // One aligner serves both phases: incoming op in IDLE, latched op otherwise.
    assign align_op   = (state_q == ST_IDLE) ? mem_op         : op_q;
    assign align_lane = (state_q == ST_IDLE) ? mem_wdata[2:0] : lane_q;

    mem_lane_align #(
        .XLEN (XLEN)
    ) u_lane_align (
        .op_i    (align_op),
        .lane_i  (align_lane),
        .sdata_i (mem_sdata),
        .rdata_i (dmem_rdata),
        .wmask_c (al_wmask_c),
        .wdata_c (al_wdata_c),
        .ldata_c (al_ldata_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        lane_d     = lane_q;
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        dmem_req_d = 1'b0;
        bus_d      = '0;
        wb_valid_d = 1'b0;
        wb_wd_d    = wb_wd_q;
        wb_wreg_d  = wb_wreg_q;
        wb_wdata_d = wb_wdata_q;
        misalign_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!op_is_mem(mem_op)) begin
                        wb_valid_d = 1'b1;
                        wb_wd_d    = mem_wd;
                        wb_wreg_d  = mem_wreg;
                        wb_wdata_d = mem_wdata;
                    end else if (op_misaligned(mem_op, mem_wdata[2:0])) begin
                        misalign_d = 1'b1;
                        wb_valid_d = 1'b1;
                        wb_wd_d    = mem_wd;
                        wb_wreg_d  = WriteDisable;
                        wb_wdata_d = XLEN'(ZeroWord);
                    end else begin
                        op_d        = mem_op;
                        lane_d      = mem_wdata[2:0];
                        wd_d        = mem_wd;
                        wreg_d      = mem_wreg;
                        dmem_req_d  = 1'b1;
                        bus_d.we    = op_is_store(mem_op);
                        bus_d.addr  = {mem_wdata[XLEN-1:3], 3'b000};
                        bus_d.wmask = al_wmask_c;
                        bus_d.wdata = op_is_store(mem_op) ? al_wdata_c : '0;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Request stays frozen until the bus takes it.
                if (dmem_ready) begin
                    state_d = ST_RESP;
                end else begin
                    dmem_req_d = 1'b1;
                    bus_d      = bus_q;
                end
            end
            ST_RESP: begin
                if (dmem_rvalid) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_wd_d    = wd_q;
                    if (op_is_load(op_q)) begin
                        wb_wreg_d  = wreg_q;
                        wb_wdata_d = al_ldata_c;
                    end else begin
                        wb_wreg_d  = WriteDisable;
                        wb_wdata_d = XLEN'(ZeroWord);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= MEM_OP_NONE;
            lane_q     <= '0;
            wd_q       <= REG_AW'(NOPRegAddr);
            wreg_q     <= WriteDisable;
            in_ready_q <= 1'b1;
            dmem_req_q <= 1'b0;
            bus_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_wd_q    <= REG_AW'(NOPRegAddr);
            wb_wreg_q  <= WriteDisable;
            wb_wdata_q <= XLEN'(ZeroWord);
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            lane_q     <= lane_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            in_ready_q <= in_ready_d;
            dmem_req_q <= dmem_req_d;
            bus_q      <= bus_d;
            wb_valid_q <= wb_valid_d;
            wb_wd_q    <= wb_wd_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = bus_q.we;
    assign dmem_addr    = bus_q.addr;
    assign dmem_wmask   = bus_q.wmask;
    assign dmem_wdata   = bus_q.wdata;
    assign wb_valid     = wb_valid_q;
    assign wb_wd        = wb_wd_q;
    assign wb_wreg      = wb_wreg_q;
    assign wb_wdata     = wb_wdata_q;
    assign mem_misalign = misalign_q;

endmodule
